// File: rtl/pair_sched_pkg.sv
// pair_sched_pkg: shared FSM encoding, default widths and count-bus unpack helper
package pair_sched_pkg;
  typedef enum logic {ARB, LOOP} state_t;
  localparam int AW_DEF = 6;
  localparam int BUS_MAX = 256;
  function automatic logic [31:0] unpack_count(input logic [BUS_MAX-1:0] bus, input int k, input int aw);
    return 32'((bus >> (k * aw)) & ((BUS_MAX'(1) << aw) - BUS_MAX'(1)));
  endfunction
endpackage

// File: rtl/pair_loop_scheduler_rr_arbiter.sv
// rr_arbiter: first eligible index at or after rr_ptr, wrapping mod NREQ
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SELW = 2
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [SELW-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] idx,
  output logic            any
);
  // scan from rr_ptr upward and keep the first hit
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && eligible[(int'(rr_ptr) + i) % NREQ]) begin
        grant[(int'(rr_ptr) + i) % NREQ] = 1'b1;
        idx = SELW'((int'(rr_ptr) + i) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pair_loop_scheduler.sv
// pair_loop_scheduler: round-robin shared nested pair-loop address generator
module pair_loop_scheduler
  import pair_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW = AW_DEF,
  parameter int SELW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] number1in,
  input  logic [NREQ*AW-1:0] number2in,
  input  logic              hold,
  output logic [AW-1:0]     readadd1,
  output logic [AW-1:0]     readadd2,
  output logic [SELW-1:0]   sel,
  output logic              valid,
  output logic [NREQ-1:0]   ack,
  output logic              busy
);
  state_t state;
  logic [SELW-1:0] rr_ptr, gidx, gnext, snext;
  logic [NREQ-1:0] grant;
  logic any;
  logic [AW-1:0] n1, n2, n1_q, n2_q;
  logic last1, last2;
  assign n1 = AW'(unpack_count(BUS_MAX'(number1in), int'(gidx), AW));
  assign n2 = AW'(unpack_count(BUS_MAX'(number2in), int'(gidx), AW));
  assign gnext = (gidx == SELW'(NREQ - 1)) ? '0 : gidx + SELW'(1);
  assign snext = (sel == SELW'(NREQ - 1)) ? '0 : sel + SELW'(1);
  assign last1 = readadd1 == n1_q - AW'(1);
  assign last2 = readadd2 == n2_q - AW'(1);
  rr_arbiter #(.NREQ(NREQ), .SELW(SELW)) u_arb (
    .eligible(req & ~ack),
    .rr_ptr(rr_ptr),
    .grant(grant),
    .idx(gidx),
    .any(any)
  );
  // grant in ARB, then walk (a1,a2) row-major over the latched counts, advancing only on consume
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB;
      rr_ptr <= '0;
      readadd1 <= '0;
      readadd2 <= '0;
      sel <= '0;
      valid <= 1'b0;
      ack <= '0;
      busy <= 1'b0;
      n1_q <= '0;
      n2_q <= '0;
    end else begin
      ack <= '0;
      if (state == ARB) begin
        if (any) begin
          sel <= gidx;
          n1_q <= n1;
          n2_q <= n2;
          if (n1 == '0 || n2 == '0) begin
            ack <= grant;
            rr_ptr <= gnext;
          end else begin
            readadd1 <= '0;
            readadd2 <= '0;
            valid <= 1'b1;
            busy <= 1'b1;
            state <= LOOP;
          end
        end
      end else if (valid && !hold) begin
        if (last1 && last2) begin
          valid <= 1'b0;
          busy <= 1'b0;
          ack <= NREQ'(1) << sel;
          rr_ptr <= snext;
          state <= ARB;
        end else if (last2) begin
          readadd1 <= readadd1 + AW'(1);
          readadd2 <= '0;
        end else begin
          readadd2 <= readadd2 + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pair_loop_scheduler.sv
// tb_pair_loop_scheduler: pair-index model with per-cycle compare plus directed literal checks
module tb_pair_loop_scheduler;
  localparam int NREQ = 4, AW = 6, SELW = 2;
  logic clk = 1'b0, reset = 1'b1, hold = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] number1in = '0, number2in = '0;
  logic [AW-1:0] readadd1, readadd2;
  logic [SELW-1:0] sel;
  logic valid, busy;
  logic [NREQ-1:0] ack;
  int checks = 0, fails = 0;

  pair_loop_scheduler #(.NREQ(NREQ), .AW(AW), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .req(req), .number1in(number1in), .number2in(number2in),
    .hold(hold), .readadd1(readadd1), .readadd2(readadd2), .sel(sel), .valid(valid),
    .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: current requester and linear pair index p; pair = (p / n2, p % n2)
  bit m_busy = 0;
  int m_sel = 0, m_n1 = 0, m_n2 = 0, m_p = 0, m_ptr = 0;
  bit [NREQ-1:0] m_ack = '0;

  always @(posedge clk) begin : model
    bit [NREQ-1:0] el;
    int k;
    el = req & ~m_ack;
    m_ack = '0;
    if (reset) begin
      m_busy = 0; m_sel = 0; m_p = 0; m_ptr = 0;
    end else if (!m_busy) begin
      k = -1;
      for (int i = 0; i < NREQ; i++)
        if (k < 0 && el[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
      if (k >= 0) begin
        m_sel = k;
        m_n1 = int'(number1in[k*AW +: AW]);
        m_n2 = int'(number2in[k*AW +: AW]);
        if (m_n1 * m_n2 == 0) begin
          m_ack[k] = 1'b1;
          m_ptr = (k + 1) % NREQ;
        end else begin
          m_busy = 1;
          m_p = 0;
        end
      end
    end else if (!hold) begin
      if (m_p == m_n1 * m_n2 - 1) begin
        m_busy = 0;
        m_ack[m_sel] = 1'b1;
        m_ptr = (m_sel + 1) % NREQ;
      end else m_p++;
    end
  end

  always @(negedge clk) begin
    chk("valid", valid, m_busy);
    chk("busy", busy, m_busy);
    chk("ack", ack, m_ack);
    chk("sel", sel, m_sel);
    if (m_busy) begin
      chk("readadd1", readadd1, m_p / m_n2);
      chk("readadd2", readadd2, m_p % m_n2);
    end
  end

  task automatic set_counts(input int k, input int a, input int b);
    number1in[k*AW +: AW] = AW'(a);
    number2in[k*AW +: AW] = AW'(b);
  endtask

  task automatic watch(input int k, input int budget, output int t, output int nv, output int np,
                       output int la1, output int la2);
    int pa1, pa2;
    pa1 = -1; pa2 = -1; t = -1; nv = 0; np = 0; la1 = -1; la2 = -1;
    for (int c = 1; c <= budget && t < 0; c++) begin
      @(negedge clk);
      if (valid) begin
        nv++;
        if (int'(readadd1) != pa1 || int'(readadd2) != pa2) np++;
        pa1 = int'(readadd1); pa2 = int'(readadd2);
        la1 = pa1; la2 = pa2;
      end
      if (ack[k]) t = c;
    end
    chk("ack_seen", t > 0, 1);
  endtask

  initial begin
    int t, nv, np, la1, la2, ns, found;
    int sels[4];
    logic [6:0] vseq;
    logic [3:0] v5;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_sel", sel, 0);
    chk("rst_a1", readadd1, 0);
    chk("rst_a2", readadd2, 0);
    reset = 1'b0;
    // 1: single requester 2, 2x3
    set_counts(2, 2, 3);
    req = 4'b0100;
    watch(2, 20, t, nv, np, la1, la2);
    chk("t1_ack_time", t, 7);
    chk("t1_nvalid", nv, 6);
    chk("t1_npairs", np, 6);
    chk("t1_last_a1", la1, 1);
    chk("t1_last_a2", la2, 2);
    chk("t1_sel", sel, 2);
    req = '0;
    @(negedge clk);
    // 2: same, with hold for 3 cycles while (0,1) shown
    req = 4'b0100;
    fork
      watch(2, 30, t, nv, np, la1, la2);
      begin
        repeat (2) @(negedge clk);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
      end
    join
    chk("t2_ack_time", t, 10);
    chk("t2_nvalid", nv, 9);
    chk("t2_npairs", np, 6);
    req = '0;
    // 3: req 1011, all 1x1, grants 0,1,3 then 0 again
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NREQ; k++) set_counts(k, 1, 1);
    req = 4'b1011;
    ns = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vseq[c] = valid;
      if (valid && ns < 4) begin sels[ns] = int'(sel); ns++; end
    end
    chk("t3_valid_seq", vseq, 7'b1010101);
    chk("t3_ngrants", ns, 4);
    chk("t3_g0", sels[0], 0);
    chk("t3_g1", sels[1], 1);
    chk("t3_g2", sels[2], 3);
    chk("t3_g3", sels[3], 0);
    req = '0;
    watch(0, 5, t, nv, np, la1, la2);
    // 4: zero outer count on requester 1
    set_counts(1, 0, 5);
    req = 4'b0010;
    watch(1, 5, t, nv, np, la1, la2);
    chk("t4_ack_time", t, 1);
    chk("t4_nvalid", nv, 0);
    req = '0;
    repeat (2) @(negedge clk);
    // 5: requester 0 keeps req high across its ack
    set_counts(0, 1, 1);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      v5[c] = valid;
      if (c == 1) chk("t5_ack", ack, 4'b0001);
      if (c == 2) chk("t5_mask_ack", ack, 0);
    end
    chk("t5_valid_seq", v5, 4'b1001);
    req = '0;
    watch(0, 5, t, nv, np, la1, la2);
    // 6: reset during loop at (0,2), then round-robin restarts at 0
    set_counts(0, 2, 3);
    req = 4'b0001;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (valid && readadd1 == 0 && readadd2 == 2) found = 1;
    end
    chk("t6_reached_02", found, 1);
    reset = 1'b1;
    req = 4'b0011;
    @(negedge clk);
    chk("t6_valid", valid, 0);
    chk("t6_ack", ack, 0);
    chk("t6_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_regrant_valid", valid, 1);
    chk("t6_regrant_sel", sel, 0);
    req = '0;
    watch(0, 20, t, nv, np, la1, la2);
    repeat (2) @(negedge clk);
    // max counts 63x63
    set_counts(0, 63, 63);
    req = 4'b0001;
    watch(0, 5000, t, nv, np, la1, la2);
    chk("max_nvalid", nv, 3969);
    chk("max_npairs", np, 3969);
    chk("max_last_a1", la1, 62);
    chk("max_last_a2", la2, 62);
    chk("max_ack_time", t, 3970);
    req = '0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
